// File: rtl/dma_pkg.sv
// dma_pkg: shared state/phase types, widths and defaults for the sprite DMA controller.
package dma_pkg;
  localparam int PAGE_W = 8;
  localparam int IDX_W = 8;
  localparam logic [15:0] OAM_PORT_DEF = 16'h2004;
  localparam int XFER_LEN_DEF = 256;
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_GET, S_PUT} state_e;
  typedef enum logic {PH_GET, PH_PUT} phase_e;
endpackage

// File: rtl/dma_phase_gen.sv
// dma_phase_gen: free-running GET/PUT bus-slot toggle, exposing the phase of the next cycle.
module dma_phase_gen
  import dma_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  output phase_e phase_nxt_o
);
  phase_e phase_q;
  assign phase_nxt_o = (phase_q == PH_GET) ? PH_PUT : PH_GET;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) phase_q <= PH_GET;
    else phase_q <= phase_nxt_o;
endmodule

// File: rtl/sprite_dma_ctrl.sv
// sprite_dma_ctrl: $4014 sprite DMA bus-sharing controller; stalls the core via RDY and copies a page to OAM_PORT.
// Define DMC_STEAL_EN to let DMC sample fetches take GET slots with priority over the OAM copy.
module sprite_dma_ctrl
  import dma_pkg::*;
#(
  parameter logic [15:0] OAM_PORT = OAM_PORT_DEF,
  parameter int          XFER_LEN = XFER_LEN_DEF
) (
  input  logic        CLK,
  input  logic        n_RES,
  input  logic        W4014,
  input  logic [7:0]  DB_IN,
  input  logic        CPU_WR,
`ifdef DMC_STEAL_EN
  input  logic        DMC_REQ,
  input  logic [15:0] DMC_ADDR,
  output logic        DMC_ACK,
`endif
  output logic        RDY,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RnW,
  output logic [7:0]  DMA_DO
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(XFER_LEN - 1);
  state_e state_q, state_d;
  phase_e phase_nxt;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic oam_q, oam_d, dmc_q, dmc_d;
  logic rdy_q, rdy_d, act_q, act_d, rnw_q, rnw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0] do_q, do_d;
  logic dmc_req;
  logic [15:0] dmc_addr;
`ifdef DMC_STEAL_EN
  logic ack_q;
  assign dmc_req = DMC_REQ;
  assign dmc_addr = DMC_ADDR;
  assign DMC_ACK = ack_q;
  always_ff @(posedge CLK or negedge n_RES)
    if (!n_RES) ack_q <= 1'b0;
    else ack_q <= (state_d == S_GET) && dmc_d;
`else
  assign dmc_req = 1'b0;
  assign dmc_addr = '0;
`endif
  dma_phase_gen u_phase (.clk_i(CLK), .rst_ni(n_RES), .phase_nxt_o(phase_nxt));
  // oam_q: a page copy is in progress; dmc_q: the current GET/PUT pair belongs to a DMC fetch
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    oam_d   = oam_q;
    dmc_d   = dmc_q;
    case (state_q)
      S_IDLE: if (W4014 || dmc_req) begin
        state_d = S_HALT;
        oam_d   = W4014;
        if (W4014) begin
          page_d = DB_IN;
          idx_d  = '0;
        end
      end
      S_HALT:  if (!CPU_WR) state_d = (phase_nxt == PH_GET) ? S_GET : S_ALIGN;
      S_ALIGN: state_d = S_GET;
      S_GET:   state_d = S_PUT;
      S_PUT:
        if (dmc_q) state_d = oam_q ? S_GET : S_IDLE;
        else if (idx_q == LAST) begin
          state_d = S_IDLE;
          oam_d   = 1'b0;
        end else begin
          state_d = S_GET;
          idx_d   = idx_q + 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_GET) dmc_d = dmc_req || !oam_d;
    rdy_d  = state_d == S_IDLE;
    act_d  = !(state_d == S_IDLE || state_d == S_HALT);
    rnw_d  = !(state_d == S_PUT && !dmc_d);
    addr_d = (state_d == S_GET) ? (dmc_d ? dmc_addr : {page_d, idx_d}) :
             (state_d == S_PUT && !dmc_d) ? OAM_PORT : 16'h0000;
    do_d   = (state_q == S_GET && !dmc_q) ? DB_IN : do_q;
  end
  always_ff @(posedge CLK or negedge n_RES)
    if (!n_RES) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      oam_q   <= 1'b0;
      dmc_q   <= 1'b0;
      rdy_q   <= 1'b1;
      act_q   <= 1'b0;
      addr_q  <= '0;
      rnw_q   <= 1'b1;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      oam_q   <= oam_d;
      dmc_q   <= dmc_d;
      rdy_q   <= rdy_d;
      act_q   <= act_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      do_q    <= do_d;
    end
  assign RDY        = rdy_q;
  assign DMA_ACTIVE = act_q;
  assign DMA_ADDR   = addr_q;
  assign DMA_RnW    = rnw_q;
  assign DMA_DO     = do_q;
endmodule
